// File: rtl/roic_pkg.sv
// Shared types for the ROIC line formatter: line FSM states and the
// pair entry stored in the output FIFO.
package roic_pkg;

   localparam int PIX_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      DONE
   } line_state_t;

   typedef struct packed {
      logic             sol;
      logic             eol;
      logic [PIX_W-1:0] pix_a;
      logic [PIX_W-1:0] pix_b;
   } pair_entry_t;

endpackage

// File: rtl/roic_sync_fifo.sv
// Single-clock first-word fall-through FIFO. The head entry is visible on
// rd_data_o whenever empty_o is low.
module roic_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];

   // Storage has no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/roic_line_formatter.sv
// Frames the reordered a/b word stream into lines and serializes one pixel
// per cycle onto a ready/valid stream with SOL/EOL markers.
//
// state  | meaning
// IDLE   | after reset, no line started; beats discarded
// ACTIVE | inside a line, pair_cnt_q counts accepted-or-dropped beats
// DONE   | line complete; further beats are a long-line error
module roic_line_formatter
   import roic_pkg::*;
#(
   parameter int DATA_WIDTH = 24,
   parameter int PIX_WIDTH  = PIX_W,
   parameter int LINE_PAIRS = 256,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sync,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data_a,
   input  logic [DATA_WIDTH-1:0] in_data_b,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [PIX_WIDTH-1:0]  out_data,
   output logic                  out_sol,
   output logic                  out_eol,
   output logic [15:0]           line_count,
   output logic                  line_len_err,
   output logic                  overflow
);

   localparam int CW = $clog2(LINE_PAIRS + 1);
   localparam logic [CW-1:0] LAST_PAIR = CW'(LINE_PAIRS - 1);

   line_state_t          state_q;
   logic [CW-1:0]        pair_cnt_q;
   logic [15:0]          line_count_q;
   logic                 err_q;
   logic                 ovf_q;
   logic                 phase_q;
   logic [PIX_WIDTH-1:0] hold_q;

   logic          line_open;
   logic [CW-1:0] cnt_eff;
   logic          beat;
   logic          last_beat;
   pair_entry_t   wr_entry;
   pair_entry_t   head;
   logic          fifo_full;
   logic          fifo_empty;
   logic          hs;
   logic          pop;
   logic          push;
   logic [PIX_WIDTH-1:0] cur_pix;

   // A sync restarts the line before the same-cycle beat is considered.
   assign line_open = sync | (state_q == ACTIVE);
   assign cnt_eff   = sync ? '0 : pair_cnt_q;
   assign beat      = in_valid & line_open;
   assign last_beat = beat & (cnt_eff == LAST_PAIR);

   assign wr_entry.sol   = (cnt_eff == '0);
   assign wr_entry.eol   = (cnt_eff == LAST_PAIR);
   assign wr_entry.pix_a = in_data_a[DATA_WIDTH-1 -: PIX_WIDTH];
   assign wr_entry.pix_b = in_data_b[DATA_WIDTH-1 -: PIX_WIDTH];

   assign hs   = ~fifo_empty & out_ready;
   assign pop  = hs & phase_q;
   assign push = beat & (~fifo_full | pop);

   roic_sync_fifo #(
      .WIDTH ($bits(pair_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (push),
      .wr_data_i (wr_entry),
      .pop_i     (pop),
      .rd_data_o (head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pair_cnt_q   <= '0;
         line_count_q <= '0;
         err_q        <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         err_q <= (sync & (state_q == ACTIVE) & (pair_cnt_q != '0)) |
                  (~sync & in_valid & (state_q == DONE));
         if (beat & fifo_full & ~pop) ovf_q <= 1'b1;
         if (last_beat) begin
            state_q      <= DONE;
            pair_cnt_q   <= '0;
            line_count_q <= line_count_q + 16'd1;
         end else if (beat) begin
            state_q    <= ACTIVE;
            pair_cnt_q <= cnt_eff + CW'(1);
         end else if (sync) begin
            state_q    <= ACTIVE;
            pair_cnt_q <= '0;
         end
      end
   end

   assign cur_pix = phase_q ? head.pix_b : head.pix_a;

   // hold_q keeps the last presented pixel so out_data never shows stale RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= 1'b0;
         hold_q  <= '0;
      end else begin
         if (hs)          phase_q <= ~phase_q;
         if (!fifo_empty) hold_q  <= cur_pix;
      end
   end

   assign out_valid    = ~fifo_empty;
   assign out_data     = fifo_empty ? hold_q : cur_pix;
   assign out_sol      = ~fifo_empty & head.sol & ~phase_q;
   assign out_eol      = ~fifo_empty & head.eol & phase_q;
   assign line_count   = line_count_q;
   assign line_len_err = err_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_roic_line_formatter.sv
// Self-checking bench for roic_line_formatter: directed table, corner-case
// sequences and random traffic against a queue-based reference model.
module tb_roic_line_formatter;

   localparam int DW = 24;
   localparam int PW = 16;
   localparam int LP = 4;
   localparam int FD = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          sync, in_valid, out_ready;
   logic [DW-1:0] in_data_a, in_data_b;
   logic          out_valid, out_sol, out_eol, line_len_err, overflow;
   logic [PW-1:0] out_data;
   logic [15:0]   line_count;

   logic          sync1, valid1, ready1;
   logic [DW-1:0] a1, b1;
   logic          ovalid1, osol1, oeol1, err1, ovf1;
   logic [PW-1:0] odata1;
   logic [15:0]   count1;

   roic_line_formatter #(
      .DATA_WIDTH(DW), .PIX_WIDTH(PW), .LINE_PAIRS(LP), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sync(sync), .in_valid(in_valid),
      .in_data_a(in_data_a), .in_data_b(in_data_b), .out_ready(out_ready),
      .out_valid(out_valid), .out_data(out_data), .out_sol(out_sol),
      .out_eol(out_eol), .line_count(line_count),
      .line_len_err(line_len_err), .overflow(overflow)
   );

   roic_line_formatter #(
      .DATA_WIDTH(DW), .PIX_WIDTH(PW), .LINE_PAIRS(1), .FIFO_DEPTH(FD)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .sync(sync1), .in_valid(valid1),
      .in_data_a(a1), .in_data_b(b1), .out_ready(ready1),
      .out_valid(ovalid1), .out_data(odata1), .out_sol(osol1),
      .out_eol(oeol1), .line_count(count1),
      .line_len_err(err1), .overflow(ovf1)
   );

   typedef struct {
      logic [15:0] d;
      bit          sol;
      bit          eol;
   } pix_t;

   typedef struct {
      bit          s;
      bit          v;
      logic [23:0] a;
      logic [23:0] b;
      bit          r;
      bit          ev;
      logic [15:0] ed;
      bit          es;
      bit          ee;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int hs_cnt = 0;
   int eol_cnt = 0;

   // Reference model state: pixels in flight plus the line rules.
   pix_t        mq[$];
   logic [15:0] m_last;
   bit          m_err;
   bit          m_ovf;
   logic [15:0] m_count;
   int          m_state;   // 0 no line yet, 1 inside a line, 2 line finished
   int          m_pos;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_last  = '0;
      m_err   = 1'b0;
      m_ovf   = 1'b0;
      m_count = '0;
      m_state = 0;
      m_pos   = 0;
   endtask

   // Called at a negedge: drive inputs, check outputs, advance the model.
   task automatic cyc(input bit s, input bit v, input logic [23:0] a,
                      input logic [23:0] b, input bit r);
      int   pairs;
      bit   hs, pop_pair, err_n, sol, eol;
      pix_t p;
      sync = s; in_valid = v; in_data_a = a; in_data_b = b; out_ready = r;
      #1;
      chk("out_valid", out_valid, mq.size() > 0);
      if (mq.size() > 0) begin
         chk("out_data", out_data, mq[0].d);
         chk("out_sol", out_sol, mq[0].sol);
         chk("out_eol", out_eol, mq[0].eol);
      end else begin
         chk("out_data_hold", out_data, m_last);
         chk("out_sol_idle", out_sol, 0);
         chk("out_eol_idle", out_eol, 0);
      end
      chk("line_len_err", line_len_err, m_err);
      chk("line_count", line_count, m_count);
      chk("overflow", overflow, m_ovf);
      if (out_valid && out_ready) hs_cnt++;
      if (out_valid && out_ready && out_eol) eol_cnt++;

      pairs    = (mq.size() + 1) / 2;
      hs       = (mq.size() > 0) && r;
      pop_pair = hs && (mq.size() % 2 == 1);
      if (mq.size() > 0) m_last = mq[0].d;
      if (hs) void'(mq.pop_front());

      err_n = 1'b0;
      if (s) begin
         if (m_state == 1 && m_pos > 0) err_n = 1'b1;
         m_state = 1;
         m_pos   = 0;
      end else if (v && m_state == 2) begin
         err_n = 1'b1;
      end
      if (v && m_state == 1) begin
         sol = (m_pos == 0);
         eol = (m_pos == LP - 1);
         m_pos++;
         if (m_pos == LP) begin
            m_state = 2;
            m_count = m_count + 16'd1;
         end
         if (pairs < FD || pop_pair) begin
            p.d = 16'(a >> (DW - PW)); p.sol = sol; p.eol = 1'b0; mq.push_back(p);
            p.d = 16'(b >> (DW - PW)); p.sol = 1'b0; p.eol = eol; mq.push_back(p);
         end else begin
            m_ovf = 1'b1;
         end
      end
      m_err = err_n;
      @(negedge clk);
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, r);
   endtask

   vec_t tv[10];

   initial begin
      sync = 0; in_valid = 0; in_data_a = '0; in_data_b = '0; out_ready = 0;
      sync1 = 0; valid1 = 0; a1 = '0; b1 = '0; ready1 = 0;
      model_reset();

      tv[0] = '{1, 1, 24'h123400, 24'h567800, 1, 0, 16'h0000, 0, 0};
      tv[1] = '{0, 1, 24'h123401, 24'h567801, 1, 1, 16'h1234, 1, 0};
      tv[2] = '{0, 1, 24'h123402, 24'h567802, 1, 1, 16'h5678, 0, 0};
      tv[3] = '{0, 1, 24'h123403, 24'h567803, 1, 1, 16'h1234, 0, 0};
      tv[4] = '{0, 0, 24'h000000, 24'h000000, 1, 1, 16'h5678, 0, 0};
      tv[5] = '{0, 0, 24'h000000, 24'h000000, 1, 1, 16'h1234, 0, 0};
      tv[6] = '{0, 0, 24'h000000, 24'h000000, 1, 1, 16'h5678, 0, 0};
      tv[7] = '{0, 0, 24'h000000, 24'h000000, 1, 1, 16'h1234, 0, 0};
      tv[8] = '{0, 0, 24'h000000, 24'h000000, 1, 1, 16'h5678, 0, 1};
      tv[9] = '{0, 0, 24'h000000, 24'h000000, 1, 0, 16'h5678, 0, 0};

      repeat (3) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sol", out_sol, 0);
      chk("rst_out_eol", out_eol, 0);
      chk("rst_line_count", line_count, 0);
      chk("rst_err", line_len_err, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_dut1_count", count1, 0);
      rst_n = 1'b1;

      // Basic line through the directed table.
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("tv%0d_valid", i), out_valid, tv[i].ev);
         chk($sformatf("tv%0d_data", i), out_data, tv[i].ed);
         chk($sformatf("tv%0d_sol", i), out_sol, tv[i].es);
         chk($sformatf("tv%0d_eol", i), out_eol, tv[i].ee);
         cyc(tv[i].s, tv[i].v, tv[i].a, tv[i].b, tv[i].r);
      end
      chk("t1_line_count", line_count, 16'd1);

      // Short line aborted by sync, then a full line.
      eol_cnt = 0;
      cyc(1, 0, '0, '0, 1);
      for (int i = 0; i < 2; i++) cyc(0, 1, $urandom, $urandom, 1);
      cyc(1, 0, '0, '0, 1);
      chk("t2_short_err", line_len_err, 1);
      for (int i = 0; i < LP; i++) cyc(0, 1, $urandom, $urandom, 1);
      idle(12, 1);
      chk("t2_eol_count", eol_cnt, 1);
      chk("t2_line_count", line_count, 16'd2);

      // Extra beat after a complete line, then sync with same-cycle beat.
      cyc(0, 1, $urandom, $urandom, 1);
      chk("t4_long_err", line_len_err, 1);
      cyc(1, 1, 24'hABCD00, 24'hEF0100, 1);
      chk("t4_sol_first", out_sol, 1);
      chk("t4_sol_data", out_data, 16'hABCD);
      for (int i = 1; i < LP; i++) cyc(0, 1, $urandom, $urandom, 1);
      cyc(0, 1, $urandom, $urandom, 1);
      chk("t4_extra_err", line_len_err, 1);
      idle(12, 1);
      chk("t4_line_count", line_count, 16'd3);

      // Fill FIFO with out_ready low; 20 beats, 16 stored.
      chk("t3_no_ovf_before", overflow, 0);
      for (int l = 0; l < 5; l++) begin
         cyc(1, 1, $urandom, $urandom, 0);
         for (int i = 1; i < LP; i++) cyc(0, 1, $urandom, $urandom, 0);
      end
      idle(3, 0);
      chk("t3_overflow", overflow, 1);
      hs_cnt = 0;
      idle(40, 1);
      chk("t3_drained_pixels", hs_cnt, 32);
      chk("t3_line_count", line_count, 16'd8);

      // Reset mid-line with FIFO partly full.
      cyc(1, 1, $urandom, $urandom, 0);
      for (int i = 1; i < LP; i++) cyc(0, 1, $urandom, $urandom, 0);
      cyc(1, 1, $urandom, $urandom, 0);
      cyc(0, 1, $urandom, $urandom, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_out_valid", out_valid, 0);
      chk("t5_out_data", out_data, 0);
      chk("t5_out_sol", out_sol, 0);
      chk("t5_out_eol", out_eol, 0);
      chk("t5_line_count", line_count, 0);
      chk("t5_err", line_len_err, 0);
      chk("t5_overflow", overflow, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) cyc(0, 1, $urandom, $urandom, 1);
      chk("t5_ignored", out_valid, 0);
      cyc(1, 1, $urandom, $urandom, 1);
      for (int i = 1; i < LP; i++) cyc(0, 1, $urandom, $urandom, 1);
      idle(10, 1);
      chk("t5_line_count", line_count, 16'd1);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++)
         cyc($urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0,
             24'($urandom), 24'($urandom), $urandom_range(0, 3) != 0);
      idle(40, 1);

      // Line counter wrap with one-pair lines, one line per cycle.
      sync1 = 1; valid1 = 1; a1 = 24'h111100; b1 = 24'h222200; ready1 = 1;
      repeat (3) @(negedge clk);
      chk("t6_count_3", count1, 16'd3);
      repeat (65533) @(negedge clk);
      chk("t6_count_wrap", count1, 16'd0);
      chk("t6_no_err", err1, 0);
      chk("t6_overflow", ovf1, 1);
      sync1 = 0; valid1 = 0;
      @(negedge clk);
      chk("t6_count_hold", count1, 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
